// File: rtl/hilo_muldiv_ctrl.sv
// hilo_muldiv_ctrl: iterative 32-cycle mul/div sequencer that owns the HI/LO pair
// and arbitrates its write port against MTHI/MTLO from MEM/WB.
module hilo_muldiv_ctrl (
    input  logic        Clk,
    input  logic        Rst_n,
    input  logic        Start,
    input  logic [1:0]  Op,
    input  logic [31:0] OpA,
    input  logic [31:0] OpB,
    input  logic        IssueHiLo,
    input  logic        Flush,
    input  logic        HiWriteIn,
    input  logic        LoWriteIn,
    input  logic [31:0] HiWData,
    input  logic [31:0] LoWData,
    output logic [31:0] HiOut,
    output logic [31:0] LoOut,
    output logic        Busy,
    output logic        Stall,
    output logic        Done
);
    typedef enum logic [1:0] {IDLE, RUN, FIX} StateT;
    StateT state, nextState;
    logic [31:0] absA, absB, rawA, quo, rem, resHi, resLo, divSub;
    logic [63:0] acc, prod;
    logic [32:0] mulSum, divShift;
    logic [4:0]  count;
    logic        isDiv, negRes, negRem, divZero, commit, isSigned, divGe, accept;

    always_ff @(posedge Clk or negedge Rst_n)
        if (!Rst_n) state <= IDLE;
        else state <= nextState;

    always_comb
        nextState = Flush ? IDLE :
                    state == IDLE ? (Start ? RUN : IDLE) :
                    state == RUN ? (count == 5'd31 ? FIX : RUN) : IDLE;

    always_comb begin
        Busy = state != IDLE;
        Stall = Busy && IssueHiLo;
        commit = state == FIX && !Flush;
        accept = state == IDLE && Start && !Flush;
    end

    // Multiply keeps the partial product in acc; divide keeps {remainder, quotient}.
    always_comb begin
        isSigned = ~Op[0];
        mulSum = {1'b0, acc[63:32]} + {1'b0, absB[0] ? absA : 32'd0};
        divShift = {acc[63:32], absA[31]};
        divGe = divShift >= {1'b0, absB};
        divSub = divShift[31:0] - absB;
        prod = negRes ? -acc : acc;
        quo = negRes ? -acc[31:0] : acc[31:0];
        rem = negRem ? -acc[63:32] : acc[63:32];
        resHi = !isDiv ? prod[63:32] : divZero ? rawA : rem;
        resLo = !isDiv ? prod[31:0] : divZero ? 32'hFFFF_FFFF : quo;
    end

    always_ff @(posedge Clk or negedge Rst_n)
        if (!Rst_n) begin
            absA <= '0;
            absB <= '0;
            rawA <= '0;
            acc <= '0;
            count <= '0;
            isDiv <= 1'b0;
            negRes <= 1'b0;
            negRem <= 1'b0;
            divZero <= 1'b0;
            HiOut <= '0;
            LoOut <= '0;
            Done <= 1'b0;
        end else begin
            if (accept) begin
                absA <= (isSigned && OpA[31]) ? -OpA : OpA;
                absB <= (isSigned && OpB[31]) ? -OpB : OpB;
                rawA <= OpA;
                isDiv <= Op[1];
                negRes <= isSigned && (OpA[31] ^ OpB[31]);
                negRem <= isSigned && OpA[31];
                divZero <= OpB == 32'd0;
                acc <= '0;
                count <= '0;
            end else if (state == RUN) begin
                count <= count + 5'd1;
                if (isDiv) begin
                    acc <= {divGe ? divSub : divShift[31:0], acc[30:0], divGe};
                    absA <= {absA[30:0], 1'b0};
                end else begin
                    acc <= {mulSum, acc[31:1]};
                    absB <= {1'b0, absB[31:1]};
                end
            end
            HiOut <= commit ? resHi : HiWriteIn ? HiWData : HiOut;
            LoOut <= commit ? resLo : LoWriteIn ? LoWData : LoOut;
            Done <= commit;
        end
endmodule

// File: tb/tb_hilo_muldiv_ctrl.sv
// tb_hilo_muldiv_ctrl: randomized + directed scoreboard bench for hilo_muldiv_ctrl.
module tb_hilo_muldiv_ctrl;
    logic        Clk = 0, Rst_n = 0, Start = 0, IssueHiLo = 0, Flush = 0;
    logic [1:0]  Op = 0;
    logic [31:0] OpA = 0, OpB = 0, HiWData = 0, LoWData = 0;
    logic        HiWriteIn = 0, LoWriteIn = 0;
    logic [31:0] HiOut, LoOut;
    logic        Busy, Stall, Done;
    int vectors = 0, miscompares = 0;
    logic [63:0] expQ[$];

    hilo_muldiv_ctrl dut (
        .Clk(Clk), .Rst_n(Rst_n), .Start(Start), .Op(Op), .OpA(OpA), .OpB(OpB),
        .IssueHiLo(IssueHiLo), .Flush(Flush), .HiWriteIn(HiWriteIn), .LoWriteIn(LoWriteIn),
        .HiWData(HiWData), .LoWData(LoWData), .HiOut(HiOut), .LoOut(LoOut),
        .Busy(Busy), .Stall(Stall), .Done(Done)
    );

    always #5 Clk = ~Clk;

    function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] q, r;
        if (op == 2'd0) return longint'($signed(a)) * longint'($signed(b));
        if (op == 2'd1) return {32'd0, a} * {32'd0, b};
        if (b == 0) return {a, 32'hFFFF_FFFF};
        if (op == 2'd2) begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
            q = $signed(a) / $signed(b);
            r = $signed(a) % $signed(b);
            return {r, q};
        end
        return {a % b, a / b};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    always @(posedge Clk) begin
        #1;
        if (Done === 1'b1) begin
            if (expQ.size() == 0) check("unexpected_done", {63'd0, Done}, 64'd0);
            else check("hilo_result", {HiOut, LoOut}, expQ.pop_front());
        end
    end

    task automatic runOp(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input bit holdIssue, input bit midStart, input bit wbFix);
        int n;
        @(negedge Clk);
        Start = 1; Op = op; OpA = a; OpB = b; IssueHiLo = holdIssue;
        expQ.push_back(model(op, a, b));
        @(posedge Clk); #1;
        Start = 0; n = 0;
        while (Busy && n < 100) begin
            n++;
            if (holdIssue) check("stall_while_busy", {63'd0, Stall}, 64'd1);
            if (midStart && n == 10) begin Start = 1; Op = ~op; OpA = $urandom; OpB = $urandom; end
            if (wbFix && n == 33) begin
                HiWriteIn = 1; HiWData = 32'hAAAA_0000; LoWriteIn = 1; LoWData = 32'h5555_AAAA;
            end
            @(posedge Clk); #1;
            Start = 0; HiWriteIn = 0; LoWriteIn = 0;
        end
        check("busy_cycles", 64'(n), 64'd33);
        check("stall_after", {63'd0, Stall}, 64'd0);
        IssueHiLo = 0;
    endtask

    task automatic abortOp(input bit useReset);
        logic [31:0] hi0, lo0;
        int n;
        @(negedge Clk);
        Start = 1; Op = 2'($urandom_range(0, 3)); OpA = $urandom; OpB = $urandom;
        hi0 = HiOut; lo0 = LoOut;
        @(posedge Clk); #1;
        Start = 0; n = 0;
        while (Busy && n < 100) begin
            n++;
            if (!useReset && n == 11) begin
                Flush = 1;
                @(posedge Clk); #1;
                Flush = 0;
                check("flush_busy_done", {62'd0, Busy, Done}, 64'd0);
                check("flush_hilo", {HiOut, LoOut}, {hi0, lo0});
            end else if (useReset && n == 21) begin
                #2 Rst_n = 0;
                #1 check("rst_busy_done", {62'd0, Busy, Done}, 64'd0);
                check("rst_hilo", {HiOut, LoOut}, 64'd0);
                @(negedge Clk) Rst_n = 1;
            end else begin
                @(posedge Clk); #1;
            end
        end
        check("abort_point", 64'(n), useReset ? 64'd21 : 64'd11);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] keep, b;
        IssueHiLo = 1;
        #12;
        check("reset_hilo", {HiOut, LoOut}, 64'd0);
        check("reset_flags", {61'd0, Busy, Stall, Done}, 64'd0);
        @(negedge Clk) Rst_n = 1; IssueHiLo = 0;
        runOp(2'd0, 32'hFFFF_FFFD, 32'd5, 0, 0, 0);
        runOp(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 0);
        runOp(2'd3, 32'd100, 32'd7, 0, 0, 0);
        runOp(2'd2, 32'hFFFF_FFF9, 32'd2, 0, 0, 0);
        runOp(2'd2, 32'h0000_1234, 32'd0, 0, 0, 0);
        runOp(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 0);
        runOp(2'd2, 32'h8765_4321, 32'd0, 0, 0, 0);
        runOp(2'd3, 32'hDEAD_BEEF, 32'd0, 0, 0, 0);
        runOp(2'd0, 32'h8000_0000, 32'h8000_0000, 0, 0, 0);
        runOp(2'd0, 32'd7, 32'hFFFF_FFF7, 1, 1, 0);
        runOp(2'd2, 32'hFFFF_FF9C, 32'd7, 0, 0, 1);
        @(negedge Clk);
        keep = LoOut; HiWriteIn = 1; HiWData = 32'hAAAA_0000;
        @(posedge Clk); #1 HiWriteIn = 0;
        check("idle_hi_write", {HiOut, LoOut}, {32'hAAAA_0000, keep});
        @(negedge Clk);
        LoWriteIn = 1; LoWData = 32'h0BAD_F00D;
        @(posedge Clk); #1 LoWriteIn = 0;
        check("idle_lo_write", {HiOut, LoOut}, {32'hAAAA_0000, 32'h0BAD_F00D});
        @(negedge Clk);
        Start = 1; Flush = 1;
        @(posedge Clk); #1 Start = 0; Flush = 0;
        check("flush_beats_start", {63'd0, Busy}, 64'd0);
        abortOp(0);
        abortOp(1);
        for (int i = 0; i < 25; i++) begin
            b = $urandom_range(0, 7) == 0 ? 32'd0 : $urandom_range(0, 1) ? $urandom : $urandom_range(1, 300);
            runOp(2'($urandom_range(0, 3)), $urandom, b, 1'($urandom_range(0, 1)), 0, 0);
        end
        repeat (3) @(posedge Clk);
        #2 check("queue_drained", 64'(expQ.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
